// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : simon_pkg
//  Brief    : Shared widths, colour codes and playback FSM states for Simon.
//  Revision : 1.0 - initial release
// ============================================================================
package simon_pkg;

  localparam int N_SEG = 32;  // colour slots in the store
  localparam int IDX_W = 5;   // log2(N_SEG)
  localparam int COL_W = 3;   // colour code width, msb marks an unassigned slot
  localparam int LED_W = 4;   // one LED per colour

  localparam logic [COL_W-1:0] c_col_red    = 3'b000;
  localparam logic [COL_W-1:0] c_col_green  = 3'b001;
  localparam logic [COL_W-1:0] c_col_blue   = 3'b010;
  localparam logic [COL_W-1:0] c_col_yellow = 3'b011;
  localparam logic [COL_W-1:0] c_col_empty  = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_SHOW  = 3'd2,
    ST_GAP   = 3'd3,
    ST_FIN   = 3'd4
  } play_state_t;

endpackage
`default_nettype wire

// File: rtl/colour_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : colour_decoder
//  Brief    : Colour code to one-hot LED pattern, plus unassigned-slot flag.
//  Revision : 1.0 - initial release
// ============================================================================
module colour_decoder
  import simon_pkg::*;
(
  input  logic [COL_W-1:0] i_code,
  output logic [LED_W-1:0] o_led,
  output logic             o_empty
);

  // An empty slot never lights anything; otherwise the low bits pick the LED.
  always_comb begin
    o_led   = '0;
    o_empty = i_code[COL_W-1];
    if (!i_code[COL_W-1]) begin
      o_led[i_code[COL_W-2:0]] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sequence_player.sv
`default_nettype none
// ============================================================================
//  Module   : sequence_player
//  Brief    : Plays the stored colour sequence (oldest first) on the LEDs,
//             paced by timer pulses, with dark gaps between colours.
//  Revision : 1.0 - initial release
// ============================================================================
module sequence_player
  import simon_pkg::*;
#(
  parameter int GAP_PULSES = 1  // dark pulses between colours, >= 1
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [IDX_W-1:0]       round,
  input  logic                   pulse,
  input  logic [N_SEG*COL_W-1:0] segs_flat,
  output logic [LED_W-1:0]       led,
  output logic                   busy,
  output logic                   done,
  output logic                   err_empty,
  output logic [IDX_W-1:0]       idx
);

  localparam int GAP_W = (GAP_PULSES > 1) ? $clog2(GAP_PULSES) : 1;

  play_state_t      r_state, w_state_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;
  logic [LED_W-1:0] r_led, w_led_next;
  logic [GAP_W-1:0] r_gap, w_gap_next;
  logic             r_busy, w_busy_next;
  logic             r_err, w_err_next;
  logic             r_done;

  logic [IDX_W-1:0] w_addr;
  logic [COL_W-1:0] w_code;
  logic [LED_W-1:0] w_dec_led;
  logic             w_dec_empty;

  // In GAP the slot under test is the next-newer one, so look one index ahead.
  assign w_addr = (r_state == ST_GAP) ? (r_idx - IDX_W'(1)) : r_idx;
  assign w_code = segs_flat[COL_W*w_addr +: COL_W];

  colour_decoder u_dec (
    .i_code  (w_code),
    .o_led   (w_dec_led),
    .o_empty (w_dec_empty)
  );

  // Next-state and next-output decode; everything defaults to holding.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_led_next   = r_led;
    w_gap_next   = r_gap;
    w_busy_next  = r_busy;
    w_err_next   = r_err;
    case (r_state)
      ST_IDLE: begin
        w_led_next = '0;
        if (start) begin
          w_idx_next   = round;
          w_busy_next  = 1'b1;
          w_err_next   = 1'b0;
          w_state_next = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (pulse) begin
          if (w_dec_empty) begin
            w_err_next   = 1'b1;
            w_state_next = ST_FIN;
          end else begin
            w_led_next   = w_dec_led;
            w_state_next = ST_SHOW;
          end
        end
      end
      ST_SHOW: begin
        if (pulse) begin
          w_led_next   = '0;
          w_gap_next   = GAP_W'(GAP_PULSES - 1);
          w_state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        w_led_next = '0;
        if (pulse) begin
          if (r_gap != '0) begin
            w_gap_next = r_gap - GAP_W'(1);
          end else if (r_idx == '0) begin
            w_state_next = ST_FIN;
          end else begin
            w_idx_next = r_idx - IDX_W'(1);
            if (w_dec_empty) begin
              w_err_next   = 1'b1;
              w_state_next = ST_FIN;
            end else begin
              w_led_next   = w_dec_led;
              w_state_next = ST_SHOW;
            end
          end
        end
      end
      ST_FIN: begin
        w_led_next   = '0;
        w_busy_next  = 1'b0;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_led_next   = '0;
        w_busy_next  = 1'b0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers; done is high exactly while in FIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_led   <= '0;
      r_gap   <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_led   <= w_led_next;
      r_gap   <= w_gap_next;
      r_busy  <= w_busy_next;
      r_err   <= w_err_next;
      r_done  <= (w_state_next == ST_FIN);
    end
  end

  assign led       = r_led;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err_empty = r_err;
  assign idx       = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_sequence_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sequence_player
//  Brief    : Scoreboard bench for sequence_player (GAP_PULSES=1 and =2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sequence_player;
  import simon_pkg::*;

  typedef struct packed {
    logic             is_done;
    logic [LED_W-1:0] led;
    logic             err;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start_a, start_b;
  logic [IDX_W-1:0]       round;
  logic                   pulse;
  logic [N_SEG*COL_W-1:0] segs_flat;
  logic [LED_W-1:0]       led_a, led_b;
  logic                   busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [IDX_W-1:0]       idx_a, idx_b;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  logic [COL_W-1:0] store [N_SEG];

  logic sel;       // which DUT the current playback targets (1 = GAP_PULSES 2)
  logic resp_en;   // the pulse being driven must produce a response
  logic pend;
  logic sel_q;

  always #5 clk = ~clk;

  sequence_player #(.GAP_PULSES(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .round(round), .pulse(pulse),
    .segs_flat(segs_flat), .led(led_a), .busy(busy_a), .done(done_a),
    .err_empty(err_a), .idx(idx_a)
  );

  sequence_player #(.GAP_PULSES(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .round(round), .pulse(pulse),
    .segs_flat(segs_flat), .led(led_b), .busy(busy_b), .done(done_b),
    .err_empty(err_b), .idx(idx_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference model: every consumed pulse yields either a LED value or the end.
  task automatic model_push(input int rnd, input int g, output int n);
    exp_t e;
    n = 0;
    for (int k = rnd; k >= 0; k--) begin
      if (store[k][COL_W-1]) begin
        e = '{is_done: 1'b1, led: '0, err: 1'b1};
        exp_q.push_back(e); n++;
        return;
      end
      e = '{is_done: 1'b0, led: 4'b0001 << store[k][1:0], err: 1'b0};
      exp_q.push_back(e); n++;
      for (int j = 0; j < g; j++) begin
        e = '{is_done: 1'b0, led: '0, err: 1'b0};
        exp_q.push_back(e); n++;
      end
    end
    e = '{is_done: 1'b1, led: '0, err: 1'b0};
    exp_q.push_back(e); n++;
  endtask

  task automatic pack_store();
    for (int k = 0; k < N_SEG; k++) segs_flat[COL_W*k +: COL_W] = store[k];
  endtask

  task automatic fill_store(input int empty_pct);
    for (int k = 0; k < N_SEG; k++) begin
      store[k] = {($urandom_range(0, 99) < empty_pct) ? 1'b1 : 1'b0,
                  2'($urandom_range(0, 3))};
    end
  endtask

  // Monitor, capture side: note which edges consume a response-producing pulse.
  always @(posedge clk) begin
    pend  <= pulse & resp_en;
    sel_q <= sel;
  end

  // Monitor, compare side: pop one expectation per consumed pulse.
  always @(negedge clk) begin
    exp_t e;
    logic [LED_W-1:0] m_led;
    logic m_done, m_err, ok_a, ok_b;
    ok_a   = 1'b0;
    ok_b   = 1'b0;
    m_led  = sel_q ? led_b  : led_a;
    m_done = sel_q ? done_b : done_a;
    m_err  = sel_q ? err_b  : err_a;
    if (pend) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_underflow: response seen, none expected (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        if (e.is_done) begin
          if (!m_done || m_err !== e.err || m_led !== '0) begin
            miscompares++;
            $display("FAIL end_of_play: done=%b err=%b led=%b, want done=1 err=%b led=0000 (t=%0t)",
                     m_done, m_err, m_led, e.err, $time);
          end
          if (sel_q) ok_b = 1'b1; else ok_a = 1'b1;
        end else if (m_led !== e.led || m_done !== 1'b0) begin
          miscompares++;
          $display("FAIL led_step: led=%b done=%b, want led=%b done=0 (t=%0t)",
                   m_led, m_done, e.led, $time);
        end
      end
    end
    if (done_a === 1'b1 && !ok_a) begin
      miscompares++;
      $display("FAIL spurious_done_a: done=1, want 0 (t=%0t)", $time);
    end
    if (done_b === 1'b1 && !ok_b) begin
      miscompares++;
      $display("FAIL spurious_done_b: done=1, want 0 (t=%0t)", $time);
    end
  end

  task automatic issue_start(input bit s, input int rnd, input bit with_pulse);
    sel   = s;
    round = IDX_W'(rnd);
    if (s) start_b = 1'b1; else start_a = 1'b1;
    pulse   = with_pulse;   // coincident pulse must be ignored
    resp_en = 1'b0;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    pulse   = 1'b0;
    chk("busy_after_start", s ? busy_b : busy_a, 1);
    chk("err_cleared_on_start", s ? err_b : err_a, 0);
    chk("idx_loaded", s ? idx_b : idx_a, rnd);
  endtask

  task automatic give_pulse();
    repeat ($urandom_range(0, 3)) @(negedge clk);
    pulse   = 1'b1;
    resp_en = 1'b1;
    @(negedge clk);
    pulse   = 1'b0;
    resp_en = 1'b0;
  endtask

  task automatic play(input bit s, input int rnd, input bit with_pulse, input bit restart);
    int n;
    pack_store();
    model_push(rnd, s ? 2 : 1, n);
    issue_start(s, rnd, with_pulse);
    for (int p = 0; p < n; p++) begin
      give_pulse();
      if (restart && p == 0) begin
        if (s) start_b = 1'b1; else start_a = 1'b1;
        round = IDX_W'($urandom_range(0, N_SEG - 1));
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
      end
    end
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("busy_after_done", s ? busy_b : busy_a, 0);
    exp_q.delete();
  endtask

  task automatic abort_run(input int rnd, input int npulses);
    int n;
    pack_store();
    model_push(rnd, 1, n);
    issue_start(1'b0, rnd, 1'b0);
    for (int p = 0; p < npulses; p++) give_pulse();
    #2 reset = 1'b1;
    #1;
    chk("abort_led_dark", led_a, 0);
    chk("abort_busy_low", busy_a, 0);
    chk("abort_idx_zero", idx_a, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    pulse   = 1'b0;
    resp_en = 1'b0;
    sel     = 1'b0;
    round   = '0;
    segs_flat = '0;
    repeat (3) @(negedge clk);
    chk("rst_led_a", led_a, 0);   chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0); chk("rst_err_a", err_a, 0);
    chk("rst_idx_a", idx_a, 0);   chk("rst_led_b", led_b, 0);
    chk("rst_busy_b", busy_b, 0); chk("rst_idx_b", idx_b, 0);
    reset = 1'b0;
    @(negedge clk);

    // Three-colour playback, oldest (yellow) first.
    fill_store(0);
    store[2] = c_col_yellow; store[1] = c_col_green; store[0] = c_col_red;
    play(1'b0, 2, 1'b0, 1'b0);
    chk("t1_err_clear", err_a, 0);

    // Empty slot aborts after slots 3 and 2; err stays set afterwards.
    fill_store(0);
    store[1] = c_col_empty;
    play(1'b0, 3, 1'b0, 1'b0);
    chk("t2_err_sticky", err_a, 1);

    // Single colour, no wrap to slot 31.
    fill_store(0);
    store[0] = c_col_blue; store[N_SEG-1] = c_col_yellow;
    play(1'b0, 0, 1'b0, 1'b0);
    chk("t3_idx_zero", idx_a, 0);

    // Start re-issued during SHOW is ignored.
    fill_store(0);
    play(1'b0, 4, 1'b0, 1'b1);

    // Start with coincident pulse: that pulse does not advance ALIGN.
    fill_store(0);
    play(1'b0, 2, 1'b1, 1'b0);

    // Reset in GAP, then in SHOW; replay afterwards from idx=round.
    fill_store(0);
    abort_run(5, 2);
    abort_run(5, 1);
    play(1'b0, 5, 1'b0, 1'b0);

    // Two-pulse gaps.
    fill_store(0);
    play(1'b1, 1, 1'b0, 1'b0);

    // Longest sequence on both variants.
    fill_store(0);
    play(1'b0, N_SEG - 1, 1'b0, 1'b0);
    play(1'b1, N_SEG - 1, 1'b0, 1'b0);

    // Randomised playbacks with occasional empty slots.
    for (int r = 0; r < 24; r++) begin
      fill_store(4);
      play(1'($urandom_range(0, 1)), $urandom_range(0, N_SEG - 1),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
